// File: rtl/inverse_leaky_relu.sv
// Streaming inverse Leaky ReLU: x = y for y >= 0, x = y * 2^SHIFT for y < 0, clamped
// to the most negative code. Two-stage valid/ready pipeline with a saturation counter.
module inverse_leaky_relu #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_WIDTH = 8,
  parameter int unsigned SHIFT      = 7,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  sat_out,
  input  logic                  sat_clr,
  output logic [CNT_WIDTH-1:0]  sat_count
);

  if (SHIFT < 1 || SHIFT >= DATA_WIDTH || FRAC_WIDTH > DATA_WIDTH) begin : g_param_check
    $error("inverse_leaky_relu: unsupported SHIFT/FRAC_WIDTH for DATA_WIDTH");
  end

  localparam logic [DATA_WIDTH-1:0] X_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] y_q;
  logic                  sign_q;
  logic                  ovf_q;
  logic                  s1_valid_q;

  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic                  sat_q, sat_d;
  logic                  valid_out_q;

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  en;

  // Depends only on registered state and ready_out, never on valid_in.
  assign en       = !valid_out_q || ready_out;
  assign ready_in = en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q        <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      s1_valid_q <= 1'b0;
    end else if (en) begin
      y_q        <= y_in;
      sign_q     <= y_in[DATA_WIDTH-1];
      ovf_q      <= (y_in[DATA_WIDTH-1 -: SHIFT+1] != '1);
      s1_valid_q <= valid_in;
    end
  end

  // Without overflow the discarded top SHIFT bits of the wide product are pure sign
  // copies, so keeping only the low DATA_WIDTH bits of {y, zeros} is exact.
  always_comb begin
    x_d   = y_q;
    sat_d = 1'b0;
    if (sign_q) begin
      if (ovf_q) begin
        x_d   = X_MIN;
        sat_d = s1_valid_q;
      end else begin
        x_d = {y_q[DATA_WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      sat_q       <= 1'b0;
      valid_out_q <= 1'b0;
    end else if (en) begin
      x_q         <= x_d;
      sat_q       <= sat_d;
      valid_out_q <= s1_valid_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (valid_out_q && ready_out && sat_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign x_out     = x_q;
  assign sat_out   = sat_q;
  assign valid_out = valid_out_q;
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_inverse_leaky_relu.sv
// Randomized and directed bench for inverse_leaky_relu; a negedge monitor scores every
// delivered beat, the saturation counter and stall stability against an arithmetic model.
module tb_inverse_leaky_relu;

  localparam int DW  = 16;
  localparam int SH  = 7;
  localparam int CW  = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] y_in;
  logic          valid_in;
  logic          ready_in;
  logic [DW-1:0] x_out;
  logic          valid_out;
  logic          ready_out;
  logic          sat_out;
  logic          sat_clr;
  logic [CW-1:0] sat_count;

  inverse_leaky_relu #(
    .DATA_WIDTH(DW),
    .FRAC_WIDTH(8),
    .SHIFT     (SH),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .y_in     (y_in),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .x_out    (x_out),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .sat_out  (sat_out),
    .sat_clr  (sat_clr),
    .sat_count(sat_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [DW:0] exp_q[$];   // {sat, x}
  int          cyc_q[$];
  int          cyc      = 0;
  int          cnt_m    = 0;
  bit          lat_mode = 0;
  bit          bp_mode  = 0;
  logic        ro_level = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // x = y for y >= 0, else y * 2^SH, clamped at -2^(DW-1).
  function automatic logic [DW:0] ref_model(input logic [DW-1:0] y);
    int v;
    v = int'($signed(y));
    if (v >= 0) return {1'b0, y};
    v = v * (1 << SH);
    if (v < -(1 << (DW-1))) return {1'b1, 1'b1, {(DW-1){1'b0}}};
    return {1'b0, v[DW-1:0]};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_out = bp_mode ? 1'($urandom_range(0, 1)) : ro_level;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: inputs change only at posedge+1, so negedge values predict the next edge.
  initial begin
    bit            stall_prev;
    logic [DW-1:0] x_prev;
    logic          sat_prev;
    logic [DW:0]   e;
    int            c;
    stall_prev = 0;
    x_prev     = '0;
    sat_prev   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        cyc_q.delete();
        cnt_m      = 0;
        stall_prev = 0;
        chk("rst_valid_out", valid_out, 0);
      end else begin
        cyc++;
        chk("sat_count", sat_count, cnt_m);
        if (stall_prev) begin
          chk("stall_x_stable", x_out, x_prev);
          chk("stall_sat_stable", sat_out, sat_prev);
          chk("stall_valid_stable", valid_out, 1);
        end
        if (valid_out && !ready_out) chk("stall_ready_in", ready_in, 0);
        if (valid_in && ready_in) begin
          exp_q.push_back(ref_model(y_in));
          cyc_q.push_back(cyc);
        end
        if (valid_out && ready_out) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            chk("x_out", x_out, e[DW-1:0]);
            chk("sat_out", sat_out, e[DW]);
            if (lat_mode) chk("latency", cyc - c, 2);
          end
        end
        if (sat_clr) cnt_m = 0;
        else if (valid_out && ready_out && sat_out && cnt_m != (1 << CW) - 1) cnt_m++;
        stall_prev = valid_out && !ready_out;
        x_prev     = x_out;
        sat_prev   = sat_out;
      end
    end
  end

  task automatic push(input logic [DW-1:0] y);
    int unsigned n;
    n        = 0;
    y_in     = y;
    valid_in = 1'b1;
    @(negedge clk);
    while (!ready_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_in) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n;
    n        = 0;
    valid_in = 1'b0;
    while ((exp_q.size() != 0 || valid_out) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  logic [DW-1:0] dir_vec [13] = '{16'h0100, 16'h0200, 16'h0080, 16'h0000,
                                  16'hFFFE, 16'hFFFC, 16'hFFFF, 16'hFFF8,
                                  16'h0001, 16'h7FFF, 16'hFF00, 16'hFEFF, 16'h8000};

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    y_in     = '0;
    sat_clr  = 1'b0;

    repeat (3) begin
      @(posedge clk);
      #1;
      y_in     = DW'($urandom);
      valid_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("reset_x_out", x_out, 0);
      chk("reset_sat_count", sat_count, 0);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ready_in, 1);
    @(posedge clk);
    #1;

    // Directed vectors plus saturation boundary, back to back with ready_out high.
    lat_mode = 1;
    foreach (dir_vec[i]) push(dir_vec[i]);
    drain();
    lat_mode = 0;
    chk("boundary_sat_count", sat_count, 2);

    // Backpressure: ramp then random samples under a random ready_out pattern.
    bp_mode = 1;
    for (int v = -16; v <= 3; v++) push(DW'(v));
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      push(DW'($urandom));
    end
    bp_mode = 0;
    drain();

    // Counter saturation.
    for (int i = 0; i < 70000; i++) push(DW'($urandom_range(16'h8000, 16'hFEFF)));
    drain();
    chk("count_saturated", sat_count, 16'hFFFF);

    // Clear on the same cycle as a saturated delivery.
    repeat (3) push(16'hC000);
    sat_clr = 1'b1;
    chk("clr_cycle_delivers", valid_out && ready_out && sat_out, 1);
    push(16'hC000);
    sat_clr = 1'b0;
    @(negedge clk);
    chk("clr_wins", sat_count, 0);
    @(posedge clk);
    #1;
    drain();

    // Asynchronous reset with both stages full and downstream stalled.
    ro_level = 1'b0;
    idle(2);
    push(16'h0011);
    push(16'h0022);
    valid_in = 1'b0;
    chk("full_before_rst", valid_out, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", valid_out, 0);
    chk("async_rst_x", x_out, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ro_level = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_rst", ready_in, 1);
    @(posedge clk);
    #1;
    push(16'h0033);
    push(16'hFFF0);
    push(16'hF000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inverse_leaky_relu.md
# inverse_leaky_relu

Streaming inverse of the Leaky ReLU activation for signed Q(DATA_WIDTH-FRAC_WIDTH).FRAC_WIDTH samples. The forward block uses alpha = 2^-SHIFT via arithmetic right shift; this block maps y back to x (x = y for y >= 0, x = y * 2^SHIFT for y < 0), with saturation.
- Placement: synthesis/decoder side of the codec, ahead of layers that need pre-activation values.
- Pipeline: two stages with valid/ready backpressure.
- Diagnostics: a saturation flag per sample and a saturating event counter.

## Interface
- DATA_WIDTH, 16, sample width, signed two's complement
- FRAC_WIDTH, 8, fractional bits; informational only, the arithmetic is format-agnostic
- SHIFT, 7, log2(1/alpha); must match the forward block
- CNT_WIDTH, 16, width of the saturation counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- y_in  in  DATA_WIDTH  signed input sample
- valid_in  in  1  y_in is valid
- ready_in  out  1  block accepts y_in this cycle
- x_out  out  DATA_WIDTH  signed reconstructed sample
- valid_out  out  1  x_out is valid
- ready_out  in  1  downstream accepts x_out this cycle
- sat_out  out  1  the current x_out was clamped; qualified by valid_out
- sat_clr  in  1  synchronous clear of sat_count
- sat_count  out  CNT_WIDTH  number of saturated samples delivered, saturating at all-ones

## Operation
- Arithmetic, y >= 0 (sign bit 0): x = y. The value 0 maps to 0.
- Arithmetic, y < 0: x = y <<< SHIFT, computed at DATA_WIDTH+SHIFT bits.
  - Overflow when y < -(2^(DATA_WIDTH-1-SHIFT)); defaults: y < -256.
  - On overflow, x = -(2^(DATA_WIDTH-1)) (16'h8000) and sat = 1.
  - y = -256 gives exactly 16'h8000 with sat = 0.
- Positive values never saturate.
- Stage 1 registers:
  - y
  - sign
  - overflow flag (upper SHIFT+1 bits of y not all ones)
  - s1_valid
- Stage 2 registers:
  - shifted or clamped x (x_out)
  - sat_out
  - valid_out
- Global enable: en = !valid_out || ready_out, and ready_in = en.
  - When en = 0, both stages hold their contents and a stage-1 bubble is not collapsed.
  - en is a pure function of registered state and ready_out; there is no combinational path from valid_in.
- Transfers:
  - Input is accepted when valid_in && ready_in.
  - Output is delivered when valid_out && ready_out.
- Counter:
  - Increments by 1 on each delivered beat with sat_out = 1.
  - Holds at 2^CNT_WIDTH-1 and does not wrap.
  - sat_clr forces 0 and wins over a simultaneous increment.
- Reset (rst asserted, asynchronous):
  - s1_valid, valid_out, sat_out = 0
  - x_out = 0
  - sat_count = 0
  - ready_in = 1 once rst deasserts, since valid_out = 0
  - Reset mid-stream discards all in-flight samples; no partial beat is delivered.

## Timing
- Latency: 2 cycles from an accepted input edge to valid_out, with ready_out held high.
- Throughput: 1 sample per cycle while ready_out = 1.
- Stall: with valid_out = 1 and ready_out = 0, x_out, sat_out and valid_out stay stable, ready_in = 0, and no input is accepted.
- Stall release: ready_out rising gives ready_in = 1 in the same cycle, and the pipeline advances on that edge.
- Data integrity: no sample is dropped or duplicated across any stall pattern.
- Counter update: sat_count changes on the edge of the delivering transfer and is visible the next cycle.
- Idle cycles (valid_in = 0) propagate as bubbles and never produce valid_out.

## Test plan
- Reset: hold rst for 3 cycles with random inputs.
  - Required: valid_out = 0, x_out = 0, sat_count = 0.
  - After release: ready_in = 1.
- Directed vectors with ready_out = 1, one sample per cycle. Expected x_out 2 cycles later, all with sat_out = 0:
  - 0100 -> 0100, 0200 -> 0200, 0080 -> 0080, 0000 -> 0000
  - FFFE -> FF00, FFFC -> FE00, FFFF -> FF80, FFF8 -> FC00
  - 0001 -> 0001, 7FFF -> 7FFF
- Saturation boundary:
  - FF00 (-256) -> 8000 with sat_out = 0.
  - FEFF (-257) -> 8000 with sat_out = 1.
  - 8000 -> 8000 with sat_out = 1.
  - Required: sat_count = 2 after delivery.
- Backpressure:
  - Stimulus: stream 20 ramp values (FFF0..0003) while toggling ready_out in a pseudo-random pattern.
  - Required: output order and values match the model exactly.
  - Required: x_out stays stable whenever valid_out && !ready_out, and ready_in = 0 in those cycles.
- Counter:
  - Drive 70000 saturating samples. Required: sat_count holds at FFFF.
  - Assert sat_clr on the same cycle as a saturated delivery. Required: sat_count = 0 the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between edges) with both stages full and ready_out = 0.
  - Required: valid_out drops immediately.
  - Required: after release, only samples injected post-reset appear.
